fpu_req_responder: RTL and testbench
====================================

# fpu_req_responder

Hardware responder for the FPU request protocol. It accepts operand/opcode requests from an initiator over a valid/ready channel and drives them into the fixed-latency `fpu` core. It captures each `fpu` result exactly LATENCY clocks after issue and returns results in order over a valid/ready response channel, with tag and opcode echoed. A credit check guarantees that no result is ever lost, whatever backpressure the response consumer applies.

## Interface
- `LATENCY`, 3: clocks from operand issue to a valid `fpu` output. Must be ≥1.
- `DEPTH`, 8: response FIFO entries. Must be a power of 2 and ≥2. DEPTH ≥ LATENCY+2 gives full throughput.
- `TAG_W`, 4: request tag width.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: a request is presented.
- `req_ready` out 1: the responder can accept a request.
- `req_a` in 32: IEEE-754 single-precision operand A.
- `req_b` in 32: operand B.
- `req_op` in 2: FPU opcode, passed through unchanged.
- `req_tag` in TAG_W: initiator tag.
- `fpu_a` out 32: to `fpu.A`.
- `fpu_b` out 32: to `fpu.B`.
- `fpu_op` out 2: to `fpu.opcode`.
- `fpu_o` in 32: from `fpu.O`.
- `rsp_valid` out 1: a response is presented.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_o` out 32: FPU result.
- `rsp_op` out 2: echoed opcode.
- `rsp_tag` out TAG_W: echoed tag.
- `credits_used` out $clog2(DEPTH)+1: count of in-flight operations plus FIFO occupancy.

## Operation
- Accept happens when `req_valid && req_ready` at a rising edge.
- `req_ready` is a combinational function of registers only: it is 1 when `credits_used < DEPTH`. It never depends on `req_valid` or `rsp_ready`.
- On accept, `fpu_a`, `fpu_b` and `fpu_op` are registered from the request. They hold their last values while idle.
- Issue tracking:
  - A LATENCY-stage shift register carries {valid, op, tag}.
  - Stage 0 is loaded on accept. Stage 0 is loaded with valid=0 when there is no accept.
- Capture: when the last stage is valid, `fpu_o` and the stage's op and tag are pushed into the response FIFO at that edge.
- Response FIFO:
  - DEPTH entries, circular, with read and write pointers that wrap modulo DEPTH.
  - The head entry drives `rsp_o`, `rsp_op` and `rsp_tag`.
  - `rsp_valid` = FIFO not empty.
  - A pop occurs on `rsp_valid && rsp_ready`.
- Ordering: responses leave strictly in acceptance order.
- Credits:
  - `credits_used` increments on accept and decrements on pop.
  - On a simultaneous accept and pop it is unchanged.
  - A pop frees a credit visible in `req_ready` from the next cycle.
- No overflow is possible: push is never blocked, because credits bound in-flight plus stored entries to DEPTH.
- Simultaneous push and pop on a full FIFO cannot occur.
- Simultaneous push and pop on an empty FIFO cannot occur, because a push becomes visible only after its edge.
- While `rsp_valid=1` and `rsp_ready=0`, `rsp_o`, `rsp_op` and `rsp_tag` hold stable.
- Reset (asynchronous, at any time) returns all of the following to 0 immediately, and discards every in-flight operation:
  - `fpu_a`, `fpu_b`, `fpu_op`
  - all shift-register valid bits
  - FIFO pointers
  - `credits_used`
  - `rsp_valid`
- After reset: `req_ready`=1, and `rsp_o`, `rsp_op` and `rsp_tag` are 0.

## Timing
- Accept at edge N:
  - `fpu_a`, `fpu_b` and `fpu_op` are valid after edge N.
  - `fpu_o` is sampled at edge N+LATENCY.
  - `rsp_valid` rises after edge N+LATENCY if the FIFO was empty.
- Minimum request-to-response latency is LATENCY clocks.
- Throughput: with `rsp_ready` held at 1 and DEPTH ≥ LATENCY+2, one accept per clock is sustained indefinitely.
- `req_ready` falls in the cycle after the accept that makes `credits_used` reach DEPTH.
- Reset release: the first accept is possible at the first rising edge with `reset_n`=1.

## Test plan
- **Single add.** After reset, send a=3F800000, b=40000000, op=0, tag=1 accepted at edge 10.
  - Required: `fpu_a`=3F800000 after edge 10.
  - Required: `rsp_valid` after edge 13 with `rsp_o`=40400000, `rsp_tag`=1, `rsp_op`=0.
- **Backpressure fill.** Hold `rsp_ready`=0 and stream requests with tags 0..9.
  - Required: exactly 8 accepts, then `req_ready`=0 and `credits_used`=8.
  - Then hold `rsp_ready`=1. Required: responses with tags 0..7 in order, and `req_ready` returns the cycle after the first pop.
- **Throughput.** Hold `rsp_ready`=1 and `req_valid`=1 for 20 clocks.
  - Required: 20 accepts, `req_ready` never deasserts, and responses appear one per clock from cycle LATENCY.
- **Stall stability.** Send mul a=40000000, b=40400000, op=2, with `rsp_ready`=0 for 5 clocks.
  - Required: `rsp_o`=40C00000 and `rsp_tag` hold stable for all 5 clocks.
  - Required: the response pops once when `rsp_ready`=1.
- **Reset mid-flight.** Accept 3 requests, then assert `reset_n`=0 between edges before any response.
  - Required: `rsp_valid`, `credits_used` and `fpu_a` are 0 immediately.
  - Required: after release, no stale responses appear and `req_ready`=1.

Source files
------------

// File: rtl/fpu_req_responder_if.sv
// Request/response channel bundle between an FPU initiator and the responder.
// The initiator side uses the master modport; the responder uses slave.
`timescale 1ns/1ps

interface fpu_req_responder_if #(
  parameter int TAG_W = 4
) ();

  // Request channel (initiator -> responder)
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_a;
  logic [31:0]      req_b;
  logic [1:0]       req_op;
  logic [TAG_W-1:0] req_tag;

  // Response channel (responder -> initiator)
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_o;
  logic [1:0]       rsp_op;
  logic [TAG_W-1:0] rsp_tag;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_op,
    output req_tag,
    input  req_ready,
    input  rsp_valid,
    input  rsp_o,
    input  rsp_op,
    input  rsp_tag,
    output rsp_ready
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_op,
    input  req_tag,
    output req_ready,
    output rsp_valid,
    output rsp_o,
    output rsp_op,
    output rsp_tag,
    input  rsp_ready
  );

endinterface

// File: rtl/fpu_req_responder.sv
// Responder for the FPU request protocol. Requests are issued into a
// fixed-latency fpu core; each result is captured LATENCY clocks after issue
// into an in-order response FIFO. A credit counter covers both in-flight
// operations and stored results, so a captured result always has a free slot.
`timescale 1ns/1ps

module fpu_req_responder #(
  parameter int LATENCY = 3,   // clocks from operand issue to valid fpu_o, >= 1
  parameter int DEPTH   = 8,   // response FIFO entries, power of 2, >= 2
  parameter int TAG_W   = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fpu_req_responder_if.slave     bus,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic [1:0]             fpu_op,
  input  logic [31:0]            fpu_o,
  output logic [$clog2(DEPTH):0] credits_used
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // ---------------------------------------------------------------------
  // Handshake qualifiers
  // ---------------------------------------------------------------------
  logic w_req_ready;
  logic w_accept;
  logic w_push;
  logic w_pop;
  logic w_rsp_valid;

  logic [CW-1:0] r_credits;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  // Ready depends on the credit register alone, never on the valid/ready inputs.
  assign w_req_ready = (r_credits < CW'(DEPTH));
  assign w_accept    = bus.req_valid & w_req_ready;
  assign w_rsp_valid = (r_wr_ptr != r_rd_ptr);
  assign w_pop       = w_rsp_valid & bus.rsp_ready;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // ---------------------------------------------------------------------
  // Operand registers driving the fpu core
  // ---------------------------------------------------------------------
  logic [31:0] r_fpu_a;
  logic [31:0] r_fpu_b;
  logic [1:0]  r_fpu_op;

  // Load operands on accept; hold the last values while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fpu_a  <= '0;
      r_fpu_b  <= '0;
      r_fpu_op <= '0;
    end else if (w_accept) begin
      r_fpu_a  <= bus.req_a;
      r_fpu_b  <= bus.req_b;
      r_fpu_op <= bus.req_op;
    end
  end

  assign fpu_a  = r_fpu_a;
  assign fpu_b  = r_fpu_b;
  assign fpu_op = r_fpu_op;

  // ---------------------------------------------------------------------
  // Issue tracking: LATENCY stages of {valid, op, tag} running alongside
  // the fpu pipeline. The last stage lines up with a valid fpu_o.
  // ---------------------------------------------------------------------
  logic [LATENCY-1:0]            r_stg_vld;
  logic [LATENCY-1:0][1:0]       r_stg_op;
  logic [LATENCY-1:0][TAG_W-1:0] r_stg_tag;

  logic [LATENCY-1:0]            w_stg_vld_next;
  logic [LATENCY-1:0][1:0]       w_stg_op_next;
  logic [LATENCY-1:0][TAG_W-1:0] w_stg_tag_next;

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // Stage 0 takes the request; a bubble enters whenever nothing is accepted.
      assign w_stg_vld_next[gi] = w_accept;
      assign w_stg_op_next[gi]  = bus.req_op;
      assign w_stg_tag_next[gi] = bus.req_tag;
    end else begin : g_rest
      assign w_stg_vld_next[gi] = r_stg_vld[gi-1];
      assign w_stg_op_next[gi]  = r_stg_op[gi-1];
      assign w_stg_tag_next[gi] = r_stg_tag[gi-1];
    end
  end

  // Valid bits are reset so a reset discards every in-flight operation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stg_vld <= '0;
    end else begin
      r_stg_vld <= w_stg_vld_next;
    end
  end

  // Payload only matters when its valid bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    r_stg_op  <= w_stg_op_next;
    r_stg_tag <= w_stg_tag_next;
  end

  // A valid last stage means fpu_o holds that operation's result right now.
  assign w_push = r_stg_vld[LATENCY-1];

  // ---------------------------------------------------------------------
  // Response FIFO storage
  // ---------------------------------------------------------------------
  logic [31:0]      r_mem_o   [DEPTH];
  logic [1:0]       r_mem_op  [DEPTH];
  logic [TAG_W-1:0] r_mem_tag [DEPTH];

  // Capture the fpu result together with its op and tag. Credits guarantee
  // a free slot, so the push is never gated.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_o[w_wr_idx]   <= fpu_o;
      r_mem_op[w_wr_idx]  <= r_stg_op[LATENCY-1];
      r_mem_tag[w_wr_idx] <= r_stg_tag[LATENCY-1];
    end
  end

  // Advance write pointer on capture and read pointer on pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Credits: accepted-but-not-popped operations
  // ---------------------------------------------------------------------

  // Count up on accept, down on pop, hold when both or neither happen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_credits <= '0;
    end else if (w_accept && !w_pop) begin
      r_credits <= r_credits + CW'(1);
    end else if (!w_accept && w_pop) begin
      r_credits <= r_credits - CW'(1);
    end
  end

  assign credits_used = r_credits;

  // ---------------------------------------------------------------------
  // Response channel outputs
  // ---------------------------------------------------------------------

  // The head is read combinationally so data arrives in the same cycle as
  // rsp_valid; it is forced to zero while empty so the outputs read 0 after
  // reset even though the storage itself is not cleared.
  always_comb begin
    bus.rsp_o   = '0;
    bus.rsp_op  = '0;
    bus.rsp_tag = '0;
    if (w_rsp_valid) begin
      bus.rsp_o   = r_mem_o[w_rd_idx];
      bus.rsp_op  = r_mem_op[w_rd_idx];
      bus.rsp_tag = r_mem_tag[w_rd_idx];
    end
  end

  assign bus.rsp_valid = w_rsp_valid;
  assign bus.req_ready = w_req_ready;

endmodule

// File: tb/tb_fpu_req_responder.sv
// Directed self-checking bench for fpu_req_responder with a small
// fixed-latency fpu stand-in.
`timescale 1ns/1ps

module tb_fpu_req_responder;

  localparam int LATENCY = 3;
  localparam int DEPTH   = 8;
  localparam int TAG_W   = 4;

  logic                   clk     = 1'b0;
  logic                   reset_n = 1'b1;
  logic [31:0]            fpu_a;
  logic [31:0]            fpu_b;
  logic [1:0]             fpu_op;
  logic [31:0]            fpu_o;
  logic [$clog2(DEPTH):0] credits_used;

  int n_checks = 0;
  int n_errors = 0;

  fpu_req_responder_if #(.TAG_W(TAG_W)) bus ();

  fpu_req_responder #(
    .LATENCY(LATENCY),
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus),
    .fpu_a       (fpu_a),
    .fpu_b       (fpu_b),
    .fpu_op      (fpu_op),
    .fpu_o       (fpu_o),
    .credits_used(credits_used)
  );

  always #5 clk = ~clk;

  // fpu stand-in: exact IEEE results for the two directed vectors, a cheap
  // deterministic mix otherwise (the responder only moves data around).
  function automatic logic [31:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    if (op == 2'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (op == 2'd2 && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ {b[15:0], b[31:16]} ^ {30'd0, op};
  endfunction

  // Result appears LATENCY-1 registers after the operand registers update,
  // i.e. it is ready to be sampled on the LATENCY-th edge after accept.
  logic [31:0] fpu_pipe [LATENCY-1];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_model(fpu_a, fpu_b, fpu_op);
    for (int i = 1; i < LATENCY-1; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_o = fpu_pipe[LATENCY-2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag);
    bus.req_valid = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_op    = op;
    bus.req_tag   = tag;
  endtask

  function automatic logic [31:0] op_a(input int n);
    return 32'h4100_0000 | 32'(n * 3 + 1);
  endfunction

  function automatic logic [31:0] op_b(input int n);
    return 32'h0002_0000 * 32'(n + 1);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int next_tag;
    bit acc;

    bus.req_valid = 1'b0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_op    = '0;
    bus.req_tag   = '0;
    bus.rsp_ready = 1'b0;

    // ---------------- reset ----------------
    #2 reset_n = 1'b0;
    tick(); tick(); tick();
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_credits", credits_used, 0);
    check("rst_fpu_a", fpu_a, 0);
    check("rst_rsp_o", bus.rsp_o, 0);
    check("rst_rsp_tag", bus.rsp_tag, 0);
    #2 reset_n = 1'b1;
    tick();

    // ---------------- single add ----------------
    drive_req(32'h3F80_0000, 32'h4000_0000, 2'd0, 4'd1);
    check("add_req_ready", bus.req_ready, 1);
    tick();
    bus.req_valid = 1'b0;
    check("add_fpu_a", fpu_a, 32'h3F80_0000);
    check("add_fpu_b", fpu_b, 32'h4000_0000);
    check("add_fpu_op", fpu_op, 0);
    check("add_credits", credits_used, 1);
    check("add_rsp_valid_n1", bus.rsp_valid, 0);
    tick();
    check("add_rsp_valid_n2", bus.rsp_valid, 0);
    tick();
    check("add_rsp_valid_n2b", bus.rsp_valid, 0);
    tick();
    check("add_rsp_valid_n3", bus.rsp_valid, 1);
    check("add_rsp_o", bus.rsp_o, 32'h4040_0000);
    check("add_rsp_tag", bus.rsp_tag, 1);
    check("add_rsp_op", bus.rsp_op, 0);
    $display("rsp tag=%0d op=%0d o=%08h", bus.rsp_tag, bus.rsp_op, bus.rsp_o);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("add_drained", bus.rsp_valid, 0);
    check("add_credits_free", credits_used, 0);

    // ---------------- backpressure fill ----------------
    n_acc    = 0;
    next_tag = 0;
    for (int c = 0; c < 12; c++) begin
      if (next_tag < 10) drive_req(op_a(next_tag), op_b(next_tag), 2'(next_tag), TAG_W'(next_tag));
      else bus.req_valid = 1'b0;
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) begin
        n_acc++;
        next_tag++;
        $display("req accepted tag=%0d", next_tag - 1);
      end
    end
    bus.req_valid = 1'b0;
    check("bp_accepts", n_acc, 8);
    check("bp_req_ready_full", bus.req_ready, 0);
    check("bp_credits_full", credits_used, 8);
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_rsp_valid", bus.rsp_valid, 1);
      check("bp_rsp_tag", bus.rsp_tag, i);
      check("bp_rsp_o", bus.rsp_o, fpu_model(op_a(i), op_b(i), 2'(i)));
      check("bp_rsp_op", bus.rsp_op, i % 4);
      $display("rsp tag=%0d op=%0d o=%08h", bus.rsp_tag, bus.rsp_op, bus.rsp_o);
      if (i == 0) check("bp_ready_before_pop", bus.req_ready, 0);
      tick();
      if (i == 0) check("bp_ready_after_pop", bus.req_ready, 1);
    end
    bus.rsp_ready = 1'b0;
    check("bp_drained", bus.rsp_valid, 0);
    check("bp_credits_free", credits_used, 0);

    // ---------------- throughput ----------------
    bus.rsp_ready = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 26; c++) begin
      if (c < 20) begin
        drive_req(op_a(c + 20), op_b(c + 20), 2'(c), TAG_W'(c));
        check("tp_req_ready", bus.req_ready, 1);
        if (bus.req_ready) n_acc++;
      end else begin
        bus.req_valid = 1'b0;
      end
      if (c >= LATENCY + 1 && c <= LATENCY + 20) begin
        check("tp_rsp_valid", bus.rsp_valid, 1);
        check("tp_rsp_tag", bus.rsp_tag, (c - LATENCY - 1) % 16);
        check("tp_rsp_o", bus.rsp_o,
              fpu_model(op_a(c - LATENCY - 1 + 20), op_b(c - LATENCY - 1 + 20), 2'(c - LATENCY - 1)));
        $display("rsp tag=%0d op=%0d o=%08h", bus.rsp_tag, bus.rsp_op, bus.rsp_o);
      end else begin
        check("tp_rsp_idle", bus.rsp_valid, 0);
      end
      tick();
    end
    check("tp_accepts", n_acc, 20);
    check("tp_credits_free", credits_used, 0);
    bus.rsp_ready = 1'b0;

    // ---------------- stall stability ----------------
    drive_req(32'h4000_0000, 32'h4040_0000, 2'd2, 4'd5);
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    check("st_not_yet", bus.rsp_valid, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("st_rsp_valid", bus.rsp_valid, 1);
      check("st_rsp_o", bus.rsp_o, 32'h40C0_0000);
      check("st_rsp_tag", bus.rsp_tag, 5);
      check("st_rsp_op", bus.rsp_op, 2);
      tick();
    end
    $display("rsp tag=%0d op=%0d o=%08h", bus.rsp_tag, bus.rsp_op, bus.rsp_o);
    check("st_credits_held", credits_used, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("st_popped", bus.rsp_valid, 0);
    check("st_credits_free", credits_used, 0);

    // ---------------- reset mid-flight ----------------
    for (int i = 1; i <= 3; i++) begin
      drive_req(op_a(40 + i), op_b(40 + i), 2'(i), TAG_W'(i));
      tick();
    end
    bus.req_valid = 1'b0;
    check("rm_credits_before", credits_used, 3);
    check("rm_fpu_a_before", fpu_a, op_a(43));
    #3 reset_n = 1'b0;
    #1;
    check("rm_rsp_valid", bus.rsp_valid, 0);
    check("rm_credits", credits_used, 0);
    check("rm_fpu_a", fpu_a, 0);
    check("rm_req_ready", bus.req_ready, 1);
    tick();
    #2 reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rm_no_stale", bus.rsp_valid, 0);
      check("rm_ready_after", bus.req_ready, 1);
    end
    check("rm_credits_after", credits_used, 0);

    // A fresh request still completes normally after the reset.
    drive_req(32'h3F80_0000, 32'h4000_0000, 2'd0, 4'd9);
    tick();
    bus.req_valid = 1'b0;
    tick(); tick(); tick();
    check("rm_fresh_valid", bus.rsp_valid, 1);
    check("rm_fresh_o", bus.rsp_o, 32'h4040_0000);
    check("rm_fresh_tag", bus.rsp_tag, 9);
    $display("rsp tag=%0d op=%0d o=%08h", bus.rsp_tag, bus.rsp_op, bus.rsp_o);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
